// File: rtl/unsigned_result_stage_pkg.sv
// Shared definitions for the unsigned ALU result stage: the opcode encoding,
// the flag bit positions and the width of one queued entry.
package unsigned_result_stage_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_DIV = 2'b01,
    OP_SUB = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  // Bit positions within the 4-bit flag vector {dz, borrow, carry, zero}.
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_CARRY  = 1;
  localparam int FLAG_BORROW = 2;
  localparam int FLAG_DZ     = 3;
  localparam int NUM_FLAGS   = 4;

  // One entry holds the opcode, both answers and the flags.
  function automatic int entry_width(input int width);
    return 2 + 2 * width + NUM_FLAGS;
  endfunction

endpackage

// File: rtl/unsigned_result_stage_result_fifo.sv
// Synchronous FIFO of DEPTH entries with an occupancy count; the head entry
// is always presented combinationally. DEPTH must be a power of two.
module result_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          push_data_i,
  output logic [DATA_W-1:0]          head_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: every signal driven here gets its default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap for free because DEPTH is a power of two.
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an empty FIFO never
  // exposes it, and leaving it out keeps it mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/unsigned_result_stage.sv
// Result stage after the unsigned ALU: queues results with their flags, hands
// them to writeback over valid/ready, and retires HI/LO and the sticky dz bit.
module unsigned_result_stage
  import unsigned_result_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           OpCode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [WIDTH-1:0]     AnswerOne,
  input  logic [WIDTH-1:0]     AnswerTwo,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     wb_data,
  output logic [NUM_FLAGS-1:0] wb_flags,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 sticky_dz,
  input  logic                 clr_sticky
);

  localparam int CW      = $clog2(DEPTH + 1);
  localparam int ENTRY_W = entry_width(WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    op_e                  op;
    logic [WIDTH-1:0]     ans_two;
    logic [WIDTH-1:0]     ans_one;
    logic [NUM_FLAGS-1:0] flags;
  } entry_t;

  entry_t               in_entry, head;
  logic [ENTRY_W-1:0]   head_raw;
  logic [CW-1:0]        count;
  logic                 push, pop;

  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 sticky_q, sticky_d;
  logic [WIDTH-1:0]     wb_data_q;
  logic [NUM_FLAGS-1:0] wb_flags_q;

  // Handshake derives only from registered occupancy: a full queue refuses
  // input even in a cycle that pops.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry         = '0;
    in_entry.op      = op_e'(OpCode);
    in_entry.ans_one = AnswerOne;
    in_entry.ans_two = AnswerTwo;
    in_entry.flags[FLAG_ZERO]   = (AnswerOne == '0);
    in_entry.flags[FLAG_CARRY]  = (in_entry.op == OP_ADD) && (AnswerOne < A);
    in_entry.flags[FLAG_BORROW] = (in_entry.op == OP_SUB) && (A < B);
    in_entry.flags[FLAG_DZ]     = (in_entry.op == OP_DIV) && (B == '0);
  end

  result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (in_entry),
    .head_data_o (head_raw),
    .count_o     (count)
  );

  assign head = entry_t'(head_raw);

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = 1'b0;
    if (pop) begin
      case (head.op)
        OP_MUL: begin
          hi_d = head.ans_two;
          lo_d = head.ans_one;
        end
        OP_DIV: begin
          // A divide by zero leaves HI/LO alone; its set beats a clear.
          if (head.flags[FLAG_DZ]) begin
            sticky_d = 1'b1;
          end else begin
            hi_d = head.ans_two;
            lo_d = head.ans_one;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      sticky_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_flags_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sticky_q <= sticky_d;
      // Remember the head so writeback outputs hold once the queue drains.
      if (out_valid) begin
        wb_data_q  <= head.ans_one;
        wb_flags_q <= head.flags;
      end
    end
  end

  assign wb_data   = out_valid ? head.ans_one : wb_data_q;
  assign wb_flags  = out_valid ? head.flags   : wb_flags_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign sticky_dz = sticky_q;

endmodule

// File: tb/tb_unsigned_result_stage.sv
// Self-checking bench: directed steps plus random traffic, compared every
// cycle against a queue-based model of the result stage.
module tb_unsigned_result_stage;
  import unsigned_result_stage_pkg::*;

  localparam int DEPTH = 2;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [1:0]       OpCode;
  logic [WIDTH-1:0] A, B, AnswerOne, AnswerTwo;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] wb_data, hi, lo;
  logic [3:0]       wb_flags;
  logic             sticky_dz, clr_sticky;

  unsigned_result_stage #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .OpCode     (OpCode),
    .A          (A),
    .B          (B),
    .AnswerOne  (AnswerOne),
    .AnswerTwo  (AnswerTwo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wb_data    (wb_data),
    .wb_flags   (wb_flags),
    .hi         (hi),
    .lo         (lo),
    .sticky_dz  (sticky_dz),
    .clr_sticky (clr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [3:0]  fl;
  } ment_t;

  ment_t       mq[$];
  ment_t       m_last;
  logic [31:0] m_hi, m_lo;
  logic        m_sticky;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference flags from the arithmetic itself: carry is the 33rd sum bit.
  function automatic logic [3:0] ref_flags(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] a1);
    logic [32:0] sum;
    logic        zero, carry, borrow, dz;
    sum    = {1'b0, a} + {1'b0, b};
    zero   = (a1 == 32'd0);
    carry  = (op == OP_ADD) && sum[32];
    borrow = (op == OP_SUB) && (a < b);
    dz     = (op == OP_DIV) && (b == 32'd0);
    return {dz, borrow, carry, zero};
  endfunction

  // Behaves like the upstream ALU: produces both answers for an operation.
  task automatic set_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    OpCode = op;
    A      = a;
    B      = b;
    case (op)
      OP_ADD: begin AnswerOne = a + b; AnswerTwo = '0; end
      OP_SUB: begin AnswerOne = a - b; AnswerTwo = '0; end
      OP_DIV: begin
        if (b != 0) begin AnswerOne = a / b; AnswerTwo = a % b; end
        else        begin AnswerOne = 32'hFFFF_FFFF; AnswerTwo = a; end
      end
      default: begin
        prod = 64'(a) * 64'(b);
        AnswerOne = prod[31:0];
        AnswerTwo = prod[63:32];
      end
    endcase
  endtask

  task automatic set_random_alu();
    logic [31:0] a, b;
    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
    case ($urandom_range(0, 3))
      0:       b = 32'd0;
      1:       b = a;
      2:       b = 32'($urandom_range(0, 15));
      default: b = 32'($urandom);
    endcase
    set_alu(2'($urandom_range(0, 3)), a, b);
  endtask

  // One clock: predict handshakes from pre-edge model state, advance the
  // model, then compare every output just after the edge.
  task automatic cycle();
    bit    do_push, do_pop, dz_retire;
    ment_t nxt, ret;
    do_push = in_valid && (mq.size() < DEPTH) && !reset;
    do_pop  = out_ready && (mq.size() != 0) && !reset;
    nxt.op  = OpCode;
    nxt.a1  = AnswerOne;
    nxt.a2  = AnswerTwo;
    nxt.fl  = ref_flags(OpCode, A, B, AnswerOne);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_hi = '0; m_lo = '0; m_sticky = 1'b0;
      m_last = '{op: 2'd0, a1: 32'd0, a2: 32'd0, fl: 4'd0};
    end else begin
      dz_retire = 1'b0;
      if (mq.size() != 0) m_last = mq[0];
      if (do_pop) begin
        ret = mq.pop_front();
        if (ret.op == OP_MUL || (ret.op == OP_DIV && !ret.fl[3])) begin
          m_hi = ret.a2;
          m_lo = ret.a1;
        end
        dz_retire = (ret.op == OP_DIV) && ret.fl[3];
      end
      if (dz_retire)       m_sticky = 1'b1;
      else if (clr_sticky) m_sticky = 1'b0;
      if (do_push) mq.push_back(nxt);
    end
    #1;
    if (do_push) in_valid = 1'b0;
    check("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("wb_data",   64'(wb_data),   64'((mq.size() != 0) ? mq[0].a1 : m_last.a1));
    check("wb_flags",  64'(wb_flags),  64'((mq.size() != 0) ? mq[0].fl : m_last.fl));
    check("hi",        64'(hi),        64'(m_hi));
    check("lo",        64'(lo),        64'(m_lo));
    check("sticky_dz", 64'(sticky_dz), 64'(m_sticky));
  endtask

  initial begin
    m_hi = '0; m_lo = '0; m_sticky = 1'b0;
    m_last = '{op: 2'd0, a1: 32'd0, a2: 32'd0, fl: 4'd0};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    set_alu(OP_ADD, 32'd0, 32'd0);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_flags", 64'(wb_flags), 64'd0);

    // Multiply retires into HI/LO.
    set_alu(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    check("mul_out_valid", 64'(out_valid), 64'd1);
    check("mul_flags", 64'(wb_flags), 64'b0001);
    cycle();
    check("mul_hi", 64'(hi), 64'd1);
    check("mul_lo", 64'(lo), 64'd0);

    // Add overflowing to zero: carry and zero, HI/LO untouched.
    set_alu(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    in_valid = 1'b1;
    cycle();
    check("add_flags", 64'(wb_flags), 64'b0011);
    cycle();
    check("add_hi", 64'(hi), 64'd1);

    // Divide by zero: sticky set wins over a same-cycle clear.
    set_alu(OP_DIV, 32'd7, 32'd0);
    in_valid = 1'b1;
    cycle();
    check("dz_flags", 64'(wb_flags), 64'b1000);
    clr_sticky = 1'b1;
    cycle();
    check("dz_sticky_set", 64'(sticky_dz), 64'd1);
    check("dz_hi_kept", 64'(hi), 64'd1);
    cycle();
    check("dz_sticky_clr", 64'(sticky_dz), 64'd0);
    clr_sticky = 1'b0;

    // Back-pressure: third subtract blocked, then drained in order.
    out_ready = 1'b0;
    set_alu(OP_SUB, 32'd3, 32'd5);
    in_valid = 1'b1;
    cycle();
    set_alu(OP_SUB, 32'd10, 32'd4);
    in_valid = 1'b1;
    cycle();
    check("full_in_ready", 64'(in_ready), 64'd0);
    set_alu(OP_SUB, 32'd9, 32'd9);
    in_valid = 1'b1;
    cycle();
    check("blocked_pending", 64'(in_valid), 64'd1);
    check("sub_head_flags", 64'(wb_flags), 64'b0100);
    check("sub_head_data", 64'(wb_data), 64'hFFFF_FFFE);
    out_ready = 1'b1;
    cycle();
    check("first_pop_no_push", 64'(in_valid), 64'd1);
    check("second_data", 64'(wb_data), 64'd6);
    cycle();
    cycle();
    check("third_flags", 64'(wb_flags), 64'b0001);
    cycle();

    // Streaming at occupancy one across pointer wrap, then reset mid-stream.
    out_ready = 1'b0;
    set_random_alu();
    in_valid = 1'b1;
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_random_alu();
      in_valid = 1'b1;
      cycle();
      check("stream_occupancy", 64'({out_valid, in_ready}), 64'b11);
    end
    set_random_alu();
    in_valid = 1'b1;
    reset = 1'b1;
    cycle();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    in_valid = 1'b0;

    // Random traffic with back-pressure, clears and occasional reset.
    for (int i = 0; i < 600; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        set_random_alu();
        in_valid = 1'b1;
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      reset      = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0; clr_sticky = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
